// File: rtl/ddr2_read_gather_if.sv
// Bus bundle for ddr2_read_gather: ring-buffer side and host read-return port.
// Optional macro GATHER_PARITY_EN adds the per-beat parity vector.
interface ddr2_read_gather_if #(
    parameter int DATA_W = 16,
    parameter int BURST  = 8,
    parameter int PTR_W  = 3
);
    logic                      rb_listen;
    logic [PTR_W-1:0]          rb_read_ptr;
    logic [DATA_W-1:0]         rb_dout;
    logic [DATA_W*BURST-1:0]   rd_data;
    logic                      rd_valid;
    logic                      rd_ready;
`ifdef GATHER_PARITY_EN
    logic [BURST-1:0]          rd_parity;
`endif

    // master: the gather block; slave: ring buffer plus host read port
    modport master (
        output rb_listen,
        output rb_read_ptr,
        input  rb_dout,
        output rd_data,
        output rd_valid,
        input  rd_ready
`ifdef GATHER_PARITY_EN
        ,
        output rd_parity
`endif
    );

    modport slave (
        input  rb_listen,
        input  rb_read_ptr,
        output rb_dout,
        input  rd_data,
        input  rd_valid,
        output rd_ready
`ifdef GATHER_PARITY_EN
        ,
        input  rd_parity
`endif
    );
endinterface

// File: rtl/ddr2_read_gather.sv
// ddr2_read_gather: opens the ring-buffer listen window after a read issue,
// then walks readPtr 0..BURST-1 gathering beats into one wide word that is
// held for the host under a valid/ready handshake.
// Optional macro GATHER_PARITY_EN adds rd_parity (even parity per beat).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for rd_issue
// WAIT  | listen high, counting down the CAS latency + burst window
// FETCH | one beat per cycle copied from rb_dout into rd_data
// HOLD  | rd_valid high, rd_data frozen until rd_ready
module ddr2_read_gather #(
    parameter int DATA_W   = 16,
    parameter int BURST    = 8,
    parameter int PTR_W    = 3,
    parameter int WAIT_CYC = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_issue,
    ddr2_read_gather_if.master   bus,
    output logic                 rd_busy,
    output logic                 rd_overrun
);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FETCH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                   state_q, state_nxt;
    logic [CNT_W-1:0]         cnt_q, cnt_nxt;
    logic                     listen_q, listen_nxt;
    logic [PTR_W-1:0]         ptr_q, ptr_nxt;
    logic [DATA_W*BURST-1:0]  data_q, data_nxt;
    logic                     valid_q, valid_nxt;
    logic                     busy_q, busy_nxt;
    logic                     overrun_q, overrun_nxt;
`ifdef GATHER_PARITY_EN
    logic [BURST-1:0]         parity_q, parity_nxt;
`endif

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            listen_q  <= 1'b0;
            ptr_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef GATHER_PARITY_EN
            parity_q  <= '0;
`endif
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            listen_q  <= listen_nxt;
            ptr_q     <= ptr_nxt;
            data_q    <= data_nxt;
            valid_q   <= valid_nxt;
            busy_q    <= busy_nxt;
            overrun_q <= overrun_nxt;
`ifdef GATHER_PARITY_EN
            parity_q  <= parity_nxt;
`endif
        end
    end

    // Next-state and next-output logic; issues outside IDLE are dropped and flagged.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        listen_nxt  = listen_q;
        ptr_nxt     = ptr_q;
        data_nxt    = data_q;
        valid_nxt   = valid_q;
        overrun_nxt = rd_issue && (state_q != S_IDLE);
`ifdef GATHER_PARITY_EN
        parity_nxt  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rd_issue) begin
                    state_nxt  = S_WAIT;
                    cnt_nxt    = CNT_W'(WAIT_CYC - 1);
                    listen_nxt = 1'b1;
                    ptr_nxt    = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_nxt  = S_FETCH;
                    listen_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            S_FETCH: begin
                data_nxt[ptr_q*DATA_W +: DATA_W] = bus.rb_dout;
`ifdef GATHER_PARITY_EN
                parity_nxt[ptr_q] = ^bus.rb_dout;
`endif
                if (ptr_q == PTR_W'(BURST - 1)) begin
                    state_nxt = S_HOLD;
                    valid_nxt = 1'b1;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.rd_ready) begin
                    state_nxt = S_IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    assign bus.rb_listen   = listen_q;
    assign bus.rb_read_ptr = ptr_q;
    assign bus.rd_data     = data_q;
    assign bus.rd_valid    = valid_q;
`ifdef GATHER_PARITY_EN
    assign bus.rd_parity   = parity_q;
`endif
    assign rd_busy         = busy_q;
    assign rd_overrun      = overrun_q;
endmodule

// File: tb/tb_ddr2_read_gather.sv
// Directed bench for ddr2_read_gather with a combinational ring-buffer model.
// Cycle c is the interval after rising edge c-1; rd_issue driven in cycle 0
// is sampled at edge 0. Outputs are checked 1 time unit after each edge.
module tb_ddr2_read_gather;
    logic clk = 1'b0;
    logic reset;
    logic rd_issue;
    logic rd_busy;
    logic rd_overrun;

    logic [15:0] mem [8];
    int nerr = 0;
    int nchk = 0;

    localparam logic [127:0] PAT_A = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
    localparam logic [127:0] PAT_B = 128'hB077_B066_B055_B044_B033_B022_B011_B000;

    ddr2_read_gather_if bus ();

    ddr2_read_gather dut (
        .clk        (clk),
        .reset      (reset),
        .rd_issue   (rd_issue),
        .bus        (bus),
        .rd_busy    (rd_busy),
        .rd_overrun (rd_overrun)
    );

    assign bus.rb_dout = mem[bus.rb_read_ptr];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_a();
        for (int k = 0; k < 8; k++) mem[k] = 16'hA000 + 16'(k);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {bus.rb_listen, bus.rb_read_ptr, bus.rd_valid, rd_busy, rd_overrun}, '0);
    endtask

    initial begin
        logic [2:0] eptr;
        reset    = 1'b1;
        rd_issue = 1'b0;
        bus.rd_ready = 1'b0;
        load_a();
        step();
        step();
        reset = 1'b0;

        // reset values
        check_idle_outputs("reset_ctl");
        check("reset_data", bus.rd_data, '0);
`ifdef GATHER_PARITY_EN
        check("reset_parity", 128'(bus.rd_parity), '0);
`endif
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle_outputs("idle");
        end

        // single read, ready high
        bus.rd_ready = 1'b1;
        rd_issue = 1'b1;
        step();
        rd_issue = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            eptr = (c >= 7 && c <= 14) ? 3'(c - 7) : 3'd0;
            check("single_listen", 128'(bus.rb_listen), 128'(c <= 6));
            check("single_ptr", 128'(bus.rb_read_ptr), 128'(eptr));
            check("single_valid", 128'(bus.rd_valid), 128'(c == 15));
            check("single_busy", 128'(rd_busy), 128'(c <= 15));
            check("single_overrun", 128'(rd_overrun), '0);
            if (c == 15) check("single_data", bus.rd_data, PAT_A);
            step();
        end

        // back-pressure
        for (int k = 0; k < 8; k++) mem[k] = 16'hB000 + 16'(k * 16'h0011);
        bus.rd_ready = 1'b0;
        rd_issue = 1'b1;
        step();
        rd_issue = 1'b0;
        for (int c = 1; c < 15; c++) step();
        for (int c = 15; c <= 24; c++) begin
            if (c == 18) load_a();
            check("bp_valid", 128'(bus.rd_valid), 128'd1);
            check("bp_busy", 128'(rd_busy), 128'd1);
            check("bp_data", bus.rd_data, PAT_B);
            step();
        end
        bus.rd_ready = 1'b1;
        check("bp_valid_last", 128'(bus.rd_valid), 128'd1);
        step();
        check("bp_valid_drop", 128'(bus.rd_valid), '0);
        check("bp_busy_drop", 128'(rd_busy), '0);
        check("bp_data_kept", bus.rd_data, PAT_B);
        step();

        // overrun: second issue in WAIT and another on the handshake cycle
        load_a();
        rd_issue = 1'b1;
        step();
        for (int c = 1; c <= 17; c++) begin
            check("ovr_overrun", 128'(rd_overrun), 128'(c == 5 || c == 16));
            check("ovr_valid", 128'(bus.rd_valid), 128'(c == 15));
            check("ovr_busy", 128'(rd_busy), 128'(c <= 15));
            if (c == 15) check("ovr_data", bus.rd_data, PAT_A);
            rd_issue = (c == 4 || c == 15);
            step();
        end
        rd_issue = 1'b0;

        // reset mid-FETCH, then a fresh read at cycle 13
        for (int k = 0; k < 8; k++) mem[k] = 16'hC000 + 16'(k);
        rd_issue = 1'b1;
        step();
        for (int c = 1; c <= 30; c++) begin
            if (c >= 7 && c <= 10)       eptr = 3'(c - 7);
            else if (c >= 20 && c <= 27) eptr = 3'(c - 20);
            else                         eptr = 3'd0;
            check("rst_listen", 128'(bus.rb_listen), 128'((c <= 6) || (c >= 14 && c <= 19)));
            check("rst_ptr", 128'(bus.rb_read_ptr), 128'(eptr));
            check("rst_valid", 128'(bus.rd_valid), 128'(c == 28));
            if (c == 11) begin
                check_idle_outputs("rst_ctl");
                check("rst_data", bus.rd_data, '0);
                load_a();
            end
            if (c == 28) check("rst_new_data", bus.rd_data, PAT_A);
            reset    = (c == 10);
            rd_issue = (c == 13);
            step();
        end
        reset    = 1'b0;
        rd_issue = 1'b0;

`ifdef GATHER_PARITY_EN
        mem[0] = 16'h0001;
        mem[1] = 16'h0003;
        for (int k = 2; k < 8; k++) mem[k] = 16'h0000;
        rd_issue = 1'b1;
        step();
        rd_issue = 1'b0;
        for (int c = 1; c < 15; c++) step();
        check("par_valid", 128'(bus.rd_valid), 128'd1);
        check("par_bits", 128'(bus.rd_parity), 128'(8'b0000_0001));
        check("par_data", bus.rd_data, 128'h0003_0001);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/ddr2_read_gather.md
Name: ddr2_read_gather

Overview:
- Read-side consumer directly downstream of ddr2_ring_buffer8.
- On a read-issue pulse from the DDR2 controller, drives the ring buffer's listen line for the DQS capture window. It then walks readPtr 0..7 and collects the eight 16-bit beats into one 128-bit word.
- Presents the 128-bit word to the host read port with a valid/ready handshake.
- Sits between the ring buffer and the controller's read-return path, on the controller clock.

Parameters:
- DATA_W, 16, width of one ring-buffer beat (ring buffer din/dout width).
- BURST, 8, beats per read burst; equals ring-buffer depth.
- PTR_W, 3, readPtr width; equals clog2(BURST).
- WAIT_CYC, 6, cycles listen stays high after issue (CAS latency plus burst transfer); legal range 1..255.

Ports:
- clk, input, 1, controller clock; all state on rising edge.
- reset, input, 1, synchronous, active-high reset.
- rd_issue, input, 1, single-cycle pulse: a read command was issued to the DRAM.
- rb_listen, output, 1, to ring buffer listen; enables strobe capture.
- rb_read_ptr, output, PTR_W, to ring buffer readPtr.
- rb_dout, input, DATA_W, from ring buffer dout; combinational function of rb_read_ptr.
- rd_data, output, DATA_W*BURST, gathered burst; beat k at bits [16k+15:16k].
- rd_valid, output, 1, rd_data holds a complete burst.
- rd_ready, input, 1, host accepts rd_data.
- rd_busy, output, 1, high in any state other than IDLE.
- rd_overrun, output, 1, one-cycle pulse: rd_issue arrived while busy and was dropped.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, rb_listen 0, rb_read_ptr 0, rd_data 0, rd_valid 0, rd_busy 0, rd_overrun 0, wait counter 0.
- All outputs are registered.
- FSM states: IDLE, WAIT, FETCH, HOLD.
- IDLE:
  - rd_issue=1 -> WAIT; load counter with WAIT_CYC-1; rb_listen<=1; rb_read_ptr<=0.
- WAIT:
  - rb_listen stays 1.
  - Counter decrements each cycle.
  - At counter==0 -> FETCH; rb_listen<=0; rb_read_ptr stays 0.
- FETCH:
  - Each cycle: rd_data slot[rb_read_ptr] <= rb_dout; rb_read_ptr increments.
  - When the slot captured is index BURST-1 -> HOLD; rd_valid<=1; rb_read_ptr wraps to 0.
- HOLD:
  - rd_valid=1 and rd_data held stable until handshake.
  - Handshake is rd_valid && rd_ready at a rising edge. On handshake -> IDLE; rd_valid<=0 next cycle.
  - rd_data retains its last value after handshake; it is don't-care when rd_valid=0.
- Latency: rd_issue sampled at edge 0 gives:
  - rb_listen high over cycles 1..WAIT_CYC;
  - rb_read_ptr 0..7 over cycles WAIT_CYC+1..WAIT_CYC+8;
  - rd_valid rising at cycle WAIT_CYC+9.
  - Defaults: rd_valid first high in cycle 15. Minimum issue-to-issue spacing with rd_ready tied high is WAIT_CYC+10.
- rd_issue handling:
  - Accepted only in IDLE.
  - rd_issue in WAIT, FETCH or HOLD, including the HOLD handshake cycle, is dropped, and rd_overrun pulses 1 the following cycle.
  - Dropped requests do not disturb state.
- rd_ready while not in HOLD has no effect.
- rd_busy is 1 in WAIT, FETCH and HOLD.
- Reset mid-operation (any state) returns to reset values next edge. A partial burst is discarded and no rd_valid is produced.
- rb_listen is never high outside WAIT.
- rb_read_ptr never exceeds BURST-1.

Optional Feature:
- Macro: GATHER_PARITY_EN.
- Defined:
  - Adds output rd_parity [BURST-1:0]; bit k = even parity (XOR-reduce) of beat k.
  - Each bit is captured in the same FETCH cycle as its beat.
  - Held with rd_data; reset value 0.
- Undefined:
  - Port is absent and no parity logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset then idle 20 cycles -> rb_listen=0, rb_read_ptr=0, rd_valid=0, rd_busy=0 throughout.
- Single read, ring buffer model loaded with beat k = 16'hA000+k, rd_ready=1, pulse rd_issue at cycle 0 -> expected:
  - rb_listen high cycles 1..6;
  - rb_read_ptr 0..7 over cycles 7..14;
  - rd_valid high in cycle 15 only;
  - rd_data = 128'hA007_A006_A005_A004_A003_A002_A001_A000.
- Back-pressure: hold rd_ready=0 for 10 cycles after rd_valid, then raise it -> rd_valid and rd_data stable while waiting; rd_valid drops one cycle after ready is sampled high; rd_busy falls in the same cycle.
- Overrun: rd_issue at cycle 0 and again at cycle 4 -> rd_overrun=1 in cycle 5 only; the single burst completes at cycle 15 unaffected.
- Reset asserted in cycle 10 (mid-FETCH) -> all outputs at reset values in cycle 11; no rd_valid. A new rd_issue at cycle 13 completes normally at cycle 28.
- With GATHER_PARITY_EN, beats 16'h0001, 16'h0003, then six beats of 16'h0000 -> rd_parity=8'b0000_0001.
